// File: rtl/divider_unit_if.sv
// Handshake and data bundle between the EX stage and the multi-cycle divider.
// The master launches operations; the slave (divider) reports busy/done/result.
interface divider_unit_if #(
  parameter int unsigned Width = 32
);
  logic             start;
  logic [1:0]       op;
  logic [Width-1:0] data1;
  logic [Width-1:0] data2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [Width-1:0] result;

  modport master (
    output start, op, data1, data2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, data1, data2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/divider_unit.sv
// Radix-2 restoring divider for RV32IM DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Division by zero and signed overflow bypass the iteration and finish in one cycle.
module divider_unit #(
  parameter int unsigned Width = 32
) (
  input  logic         clk,
  input  logic         reset,
  divider_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e           state_q;
  logic [Width-1:0] quo_q, rem_q, dvs_q, result_q;
  logic [4:0]       cnt_q;
  logic             op_rem_q, neg_quo_q, neg_rem_q, busy_q, done_q;

  logic             signed_op, sign1, sign2, div_zero, overflow;
  logic [Width-1:0] abs1, abs2, quo_fix, rem_fix;
  logic [Width:0]   shifted, diff;

  localparam logic [Width-1:0] MinInt = {1'b1, {(Width-1){1'b0}}};

  always_comb begin
    signed_op = ~bus.op[0];
    sign1     = signed_op & bus.data1[Width-1];
    sign2     = signed_op & bus.data2[Width-1];
    abs1      = sign1 ? -bus.data1 : bus.data1;
    abs2      = sign2 ? -bus.data2 : bus.data2;
    div_zero  = (bus.data2 == '0);
    overflow  = signed_op && (bus.data1 == MinInt) && (bus.data2 == '1);
    // Partial remainder never exceeds the divisor, so Width+1 bits hold the shifted value.
    shifted   = {rem_q, quo_q[Width-1]};
    diff      = shifted - {1'b0, dvs_q};
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start && !bus.flush) begin
            op_rem_q <= bus.op[1];
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            // Special cases preload quotient/remainder so FINISH needs no extra path.
            if (div_zero) begin
              quo_q     <= '1;
              rem_q     <= bus.data1;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= StFinish;
            end else if (overflow) begin
              quo_q     <= MinInt;
              rem_q     <= '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= StFinish;
            end else begin
              quo_q     <= abs1;
              rem_q     <= '0;
              dvs_q     <= abs2;
              neg_quo_q <= sign1 ^ sign2;
              neg_rem_q <= sign1;
              state_q   <= StCalc;
            end
          end
        end
        StCalc: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            if (!diff[Width]) begin
              rem_q <= diff[Width-1:0];
              quo_q <= {quo_q[Width-2:0], 1'b1};
            end else begin
              rem_q <= shifted[Width-1:0];
              quo_q <= {quo_q[Width-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= StFinish;
          end
        end
        StFinish: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
          if (!bus.flush) begin
            result_q <= op_rem_q ? rem_fix : quo_fix;
            done_q   <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: expected results go into a queue at launch,
// a negedge monitor pops and compares on every DONE pulse.
module tb_divider_unit;
  logic clk;
  logic reset;

  divider_unit_if #(.Width(32)) dif ();

  divider_unit #(.Width(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic        prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every DONE must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dif.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got result %h, expected no DONE", dif.result);
      end else begin
        check("result", dif.result, exp_q.pop_front());
      end
      if (prev_done) check("done_single_pulse", 32'(prev_done), 32'd0);
    end
    prev_done = (dif.done === 1'b1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after an edge; START is sampled on the next edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int k, nbusy;
    dif.start = 1'b1;
    dif.op    = op;
    dif.data1 = a;
    dif.data2 = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    k = 0;
    nbusy = 0;
    while (dif.done !== 1'b1 && k < 100) begin
      if (dif.busy === 1'b1) nbusy++;
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", 32'(k), 32'(lat));
    check("busy_cycles", 32'(nbusy), 32'(lat));
  endtask

  task automatic launch_untracked(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    dif.start = 1'b1;
    dif.op    = op;
    dif.data1 = a;
    dif.data2 = b;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
  endtask

  initial begin
    int k;
    reset     = 1'b0;
    dif.start = 1'b0;
    dif.op    = 2'b00;
    dif.data1 = '0;
    dif.data2 = '0;
    dif.flush = 1'b0;
    wait_cycles(3);
    check("reset_busy", 32'(dif.busy), 32'd0);
    check("reset_done", 32'(dif.done), 32'd0);
    check("reset_result", dif.result, 32'h0);
    reset = 1'b1;
    wait_cycles(1);

    // Back-to-back: each run_op launches in the previous DONE cycle.
    run_op(OpDiv,  32'd100,       32'd7,         32'd14,        33);
    run_op(OpRem,  32'd100,       32'd7,         32'd2,         33);
    run_op(OpDiv,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  33);
    run_op(OpRem,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  33);
    run_op(OpRemu, 32'hFFFFFFF9,  32'd2,         32'd1,         33);
    run_op(OpDivu, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  33);
    run_op(OpDiv,  32'd5,         32'd0,         32'hFFFFFFFF,  1);
    run_op(OpRemu, 32'd5,         32'd0,         32'd5,         1);
    run_op(OpDiv,  32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1);
    run_op(OpRem,  32'h80000000,  32'hFFFFFFFF,  32'd0,         1);
    run_op(OpDiv,  32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  33);

    // START while busy must be ignored.
    dif.start = 1'b1;
    dif.op    = OpDivu;
    dif.data1 = 32'd1000;
    dif.data2 = 32'd10;
    exp_q.push_back(32'd100);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_cycles(9);
    launch_untracked(OpDivu, 32'd9, 32'd3);
    k = 10;
    while (dif.done !== 1'b1 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("busy_ignore_latency", 32'(k), 32'd33);

    // Flush mid-CALC keeps the previous result.
    run_op(OpDivu, 32'h1234, 32'd1, 32'h1234, 33);
    launch_untracked(OpDiv, 32'd50, 32'd5);
    wait_cycles(14);
    dif.flush = 1'b1;
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    check("flush_busy", 32'(dif.busy), 32'd0);
    check("flush_done", 32'(dif.done), 32'd0);
    check("flush_result", dif.result, 32'h1234);
    wait_cycles(40);
    run_op(OpDiv, 32'd50, 32'd5, 32'd10, 33);

    // Reset mid-CALC aborts the operation.
    wait_cycles(1);
    launch_untracked(OpDivu, 32'd77, 32'd7);
    wait_cycles(19);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("midreset_busy", 32'(dif.busy), 32'd0);
    check("midreset_done", 32'(dif.done), 32'd0);
    check("midreset_result", dif.result, 32'h0);
    wait_cycles(40);

    // FLUSH beats START in IDLE.
    dif.start = 1'b1;
    dif.flush = 1'b1;
    dif.op    = OpDivu;
    dif.data1 = 32'd20;
    dif.data2 = 32'd4;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    dif.flush = 1'b0;
    check("flush_start_busy", 32'(dif.busy), 32'd0);
    wait_cycles(40);
    check("flush_start_result", dif.result, 32'h0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
# divider_unit

Multi-cycle integer divider for the RV32IM M-extension DIV, DIVU, REM and REMU instructions. It sits in the EX stage beside the single-cycle ALU and takes the same operand buses from the ID/EX register. Its RESULT feeds the EX-stage result mux ahead of the EX/MEM register. BUSY drives the hazard unit's stall of IF/ID/EX until DONE.

## Interface
- WIDTH, 32: operand/result width; only 32 is supported.
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-low reset; sampled on CLK rising edge.
- START  in  1  launch request; honoured only in IDLE.
- OP  in  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
- DATA1  in  32  dividend; sampled on the START edge only.
- DATA2  in  32  divisor; sampled on the START edge only.
- FLUSH  in  1  abort current operation (branch mispredict / pipeline flush).
- BUSY  out  1  high while an operation is in flight.
- DONE  out  1  one-cycle pulse; RESULT is valid in the same cycle.
- RESULT  out  32  quotient or remainder; held until the next DONE or reset.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE: START=1 and FLUSH=0 -> latch OP, DATA1, DATA2.
  - Divisor = 0 or signed overflow -> FINISH.
  - Otherwise -> CALC with the iteration counter = 0.
- Signed ops: divide magnitudes |DATA1|, |DATA2| as unsigned; record the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
- CALC: one radix-2 restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the 33-bit partial remainder.
  - Keep the difference if non-negative and set quo[0]=1; otherwise restore.
  - Counter 0..31; after the step with counter=31 -> FINISH.
- FINISH: apply the sign fix (two's-complement negate quotient/remainder when the recorded sign is 1), write RESULT, pulse DONE, -> IDLE.
- Special cases, resolved without iterating (RISC-V defined):
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> DATA1.
  - Overflow (DIV/REM with DATA1=0x80000000, DATA2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- START while BUSY=1: ignored; latched operands unchanged.
- FLUSH=1 in CALC or FINISH: next state IDLE, no DONE, RESULT keeps its previous value.
- FLUSH and START both high in IDLE: FLUSH wins, nothing is launched.
- RESET=0: state IDLE, BUSY=0, DONE=0, RESULT=0, counter=0, regardless of state (including mid-CALC).

## Timing
- Reset values: BUSY=0, DONE=0, RESULT=0x00000000.
- Normal operation, START sampled at edge t:
  - BUSY=1 from after edge t through edge t+32.
  - Edge t+33 writes RESULT; DONE=1 and BUSY=0 for the cycle after edge t+33.
  - Latency is 33 cycles.
- Special case, START at edge t: FINISH occupies edge t+1; DONE=1 after edge t+1; BUSY=1 for exactly one cycle.
- DONE is never high for two consecutive cycles.
- A new START may be sampled in the DONE cycle, giving back-to-back operation.
- BUSY and DONE are registered, with no combinational path from inputs.
- RESULT changes only on the edge that raises DONE, or on reset.

## Test plan
- DIV 100/7 with START at edge t:
  - RESULT=14 and DONE pulse after edge t+33.
  - BUSY high for exactly 33 cycles.
  - REM on the same operands -> 2.
- Signs:
  - DIV -7/2 -> 0xFFFFFFFD (-3).
  - REM -7/2 -> 0xFFFFFFFF (-1).
  - REMU 0xFFFFFFF9/2 -> 1.
  - DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Special cases, each with DONE one cycle after START:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM on the same operands -> 0.
- Busy behaviour:
  - START with DIVU 1000/10, then START again at cycle 10 with 9/3: the second START is ignored and RESULT=100.
  - START in the DONE cycle: accepted, next RESULT correct.
- FLUSH at cycle 15 of a DIV 50/5, after a prior RESULT=0x1234: no DONE, BUSY low the next cycle, RESULT stays 0x1234. A following DIV 50/5 -> 10.
- Reset:
  - RESET=0 at cycle 20 of CALC -> next cycle BUSY=0, DONE=0, RESULT=0, and no DONE ever appears for the aborted op.
  - FLUSH+START together in IDLE -> BUSY stays 0.
